// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : Program counter plus a single-outstanding instruction memory
//            reader that hands fetched words to the decoder over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    localparam logic [31:0] c_PC_STEP = 32'd4;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic        r_kill;
    logic        w_kill_next;
    logic        w_capture;
    logic [31:0] w_target;
    logic [31:0] r_instruction;
    logic [31:0] r_instr_pc;

    assign w_target    = {redirect_pc[31:2], 2'b00};
    assign mem_req     = (r_state == S_REQ);
    assign mem_addr    = r_pc;
    assign instr_valid = (r_state == S_OUT);
    assign instruction = r_instruction;
    assign instr_pc    = r_instr_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_kill  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_kill  <= w_kill_next;
        end
    end

    // Redirect outranks everything once fetching has started; r_kill remembers
    // that the response still in flight belongs to the abandoned PC.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_kill_next  = r_kill;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_next = S_REQ;
            end
            S_REQ: begin
                w_state_next = S_WAIT;
                w_kill_next  = redirect;
                if (redirect) begin
                    w_pc_next = w_target;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    w_kill_next = 1'b0;
                    if (r_kill || redirect) begin
                        w_state_next = S_REQ;
                        if (redirect) begin
                            w_pc_next = w_target;
                        end
                    end else begin
                        w_capture    = 1'b1;
                        w_pc_next    = r_pc + c_PC_STEP;
                        w_state_next = S_OUT;
                    end
                end else if (redirect) begin
                    w_kill_next = 1'b1;
                    w_pc_next   = w_target;
                end
            end
            S_OUT: begin
                if (redirect) begin
                    w_pc_next    = w_target;
                    w_state_next = S_REQ;
                end else if (instr_ready) begin
                    w_state_next = S_REQ;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instruction <= 32'h0000_0000;
            r_instr_pc    <= RESET_PC;
        end else if (w_capture) begin
            r_instruction <= mem_rdata;
            r_instr_pc    <= r_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Directed and random checks of instr_fetch against a transaction
//            level fetch model and a latency-programmable memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam logic [31:0] c_WRAP_PC = 32'hFFFF_FFFC;

    logic        clk;
    logic        reset;
    logic        mem_req, mem_rvalid, redirect, instr_valid, instr_ready;
    logic [31:0] mem_addr, mem_rdata, redirect_pc, instruction, instr_pc;
    logic        mem_req2, mem_rvalid2, instr_valid2;
    logic [31:0] mem_addr2, mem_rdata2, instruction2, instr_pc2;

    instr_fetch u_dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .instr_pc(instr_pc)
    );

    instr_fetch #(.RESET_PC(c_WRAP_PC)) u_dut_wrap (
        .clk(clk), .reset(reset),
        .mem_req(mem_req2), .mem_addr(mem_addr2),
        .mem_rvalid(mem_rvalid2), .mem_rdata(mem_rdata2),
        .redirect(1'b0), .redirect_pc(32'h0000_0000),
        .instr_valid(instr_valid2), .instr_ready(1'b1),
        .instruction(instruction2), .instr_pc(instr_pc2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level expectation of the fetch unit.
    logic        starting, exp_req, busy, stale, hold;
    logic [31:0] exp_pc, h_pc, h_instr;
    // Bench memory for the main instance.
    int          mem_lat;
    int          cnt;
    logic [31:0] raddr;
    // Bench memory and observation log for the wrap instance.
    logic        pend2;
    logic [31:0] paddr2;
    int          n_req2;
    logic [31:0] addr2 [2];
    logic        got2;
    logic [31:0] pc2, in2;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) + 32'd1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        starting = 1'b1;
        exp_req  = 1'b0;
        busy     = 1'b0;
        stale    = 1'b0;
        hold     = 1'b0;
        exp_pc   = 32'h0000_0000;
        h_pc     = 32'h0000_0000;
        h_instr  = 32'h0000_0000;
    endtask

    task automatic cycle(input logic rst_in, input logic rd, input logic [31:0] tgt,
                         input logic rdy, input logic spur);
        logic        rv;
        logic [31:0] rdat;
        logic        nreq;
        logic [31:0] tgt_al;
        @(negedge clk);
        check("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
        if (exp_req) check("mem_addr", mem_addr, exp_pc);
        check("instr_valid", {31'd0, instr_valid}, {31'd0, hold});
        check("instruction", instruction, h_instr);
        check("instr_pc", instr_pc, h_pc);

        rv   = 1'b0;
        rdat = $urandom;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                rv   = 1'b1;
                rdat = mem_word(raddr);
            end
        end
        if (mem_req) begin
            raddr = mem_addr;
            cnt   = mem_lat;
        end
        if (spur && !rv && !busy) rv = 1'b1;

        if (mem_req2 && n_req2 < 2) begin
            addr2[n_req2] = mem_addr2;
            n_req2++;
        end
        if (instr_valid2 && !got2) begin
            got2 = 1'b1;
            pc2  = instr_pc2;
            in2  = instruction2;
        end
        mem_rvalid2 = pend2;
        mem_rdata2  = pend2 ? mem_word(paddr2) : $urandom;
        pend2       = mem_req2;
        paddr2      = mem_addr2;

        reset       = rst_in;
        redirect    = rd;
        redirect_pc = tgt;
        instr_ready = rdy;
        mem_rvalid  = rv;
        mem_rdata   = rdat;

        tgt_al = {tgt[31:2], 2'b00};
        nreq   = 1'b0;
        if (rst_in) begin
            model_reset();
        end else if (starting) begin
            starting = 1'b0;
            nreq     = 1'b1;
        end else if (exp_req) begin
            busy  = 1'b1;
            stale = rd;
            if (rd) exp_pc = tgt_al;
        end else if (busy) begin
            if (rv) begin
                busy = 1'b0;
                if (stale || rd) begin
                    nreq = 1'b1;
                    if (rd) exp_pc = tgt_al;
                end else begin
                    hold    = 1'b1;
                    h_pc    = exp_pc;
                    h_instr = mem_word(exp_pc);
                    exp_pc  = exp_pc + 32'd4;
                end
                stale = 1'b0;
            end else if (rd) begin
                stale  = 1'b1;
                exp_pc = tgt_al;
            end
        end else if (hold) begin
            if (rd || rdy) begin
                hold = 1'b0;
                nreq = 1'b1;
                if (rd) exp_pc = tgt_al;
            end
        end
        if (!rst_in) exp_req = nreq;
    endtask

    task automatic idle_cycles(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, rdy, 1'b0);
    endtask

    initial begin
        reset = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_rvalid2 = 1'b0; mem_rdata2 = 32'h0;
        mem_lat = 1; cnt = 0; raddr = 32'h0; pend2 = 1'b0; paddr2 = 32'h0;
        n_req2 = 0; got2 = 1'b0; pc2 = 32'h0; in2 = 32'h0;
        addr2[0] = 32'h0; addr2[1] = 32'h0;
        model_reset();
        #1 reset = 1'b1;

        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        idle_cycles(11, 1'b1);

        // Decoder stall, with stray rvalid pulses that must be ignored.
        for (int i = 0; i < 10 && !hold; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("wait_hold_stall", {31'd0, hold}, 32'd1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, i[0]);
        idle_cycles(4, 1'b1);

        // Redirect while waiting on a slow response.
        mem_lat = 3;
        for (int i = 0; i < 10 && !(busy && cnt > 1); i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("wait_busy_redirect", {31'd0, busy}, 32'd1);
        cycle(1'b0, 1'b1, 32'h0000_0103, 1'b1, 1'b0);
        idle_cycles(12, 1'b1);

        // Redirect in the same cycle as the response.
        mem_lat = 2;
        for (int i = 0; i < 10 && !(busy && cnt == 1); i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("wait_resp_redirect", cnt, 32'd1);
        cycle(1'b0, 1'b1, 32'h0000_0202, 1'b1, 1'b0);
        idle_cycles(8, 1'b1);

        // Redirect while an instruction is being accepted.
        mem_lat = 1;
        for (int i = 0; i < 10 && !hold; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("wait_hold_redirect", {31'd0, hold}, 32'd1);
        cycle(1'b0, 1'b1, 32'h0000_0300, 1'b1, 1'b0);
        idle_cycles(6, 1'b1);

        // Reset during WAIT; the orphaned response lands just after release.
        mem_lat = 3;
        for (int i = 0; i < 10 && !(busy && cnt == 3); i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("wait_busy_reset", cnt, 32'd3);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        idle_cycles(10, 1'b1);

        check("wrap_req0", addr2[0], c_WRAP_PC);
        check("wrap_req1", addr2[1], 32'h0000_0000);
        check("wrap_got", {31'd0, got2}, 32'd1);
        check("wrap_instr_pc", pc2, c_WRAP_PC);
        check("wrap_instruction", in2, 32'h4000_0000);

        for (int i = 0; i < 3000; i++) begin
            mem_lat = int'($urandom_range(1, 3));
            cycle(($urandom % 300) == 0,
                  ($urandom % 8) == 0,
                  $urandom,
                  ($urandom % 3) != 0,
                  (cnt == 0) && (($urandom % 6) == 0));
        end
        idle_cycles(6, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
